// File: rtl/data_memory_if.sv
// Request/response bus between the execute stage and data_memory_ctrl.
// The memory side uses the slave modport; the requester uses master.
interface data_memory_if #(
  parameter int unsigned WORDSIZE   = 64,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [WORDSIZE-1:0]   req_wdata;
  logic                  resp_valid;
  logic [WORDSIZE-1:0]   resp_rdata;
  logic                  resp_error;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error, init_done
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with sized, sign/zero-extended accesses and a
// post-reset clear sweep. Optional counters behind DATA_MEMORY_STATS_EN.
module data_memory_ctrl #(
  parameter int unsigned WORDSIZE   = 64,
  parameter int unsigned SIZE       = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave bus
`ifdef DATA_MEMORY_STATS_EN
  ,
  output logic [31:0]  stat_loads,
  output logic [31:0]  stat_stores,
  output logic [31:0]  stat_errors
`endif
);

  localparam int unsigned BYTES  = WORDSIZE / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned ROW_W  = ADDR_WIDTH - LANE_W;
  localparam int unsigned CNT_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned BIT_W  = $clog2(WORDSIZE);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_error_q, resp_error_d;
  logic [WORDSIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic [WORDSIZE-1:0] mem_q [SIZE];

  logic [ROW_W-1:0]    row_c;
  logic [LANE_W-1:0]   lane_c;
  logic [CNT_W-1:0]    row_idx_c;
  logic                accept_c, err_c, init_we_c, store_we_c, sign_c;
  logic [BYTES-1:0]    byte_en_c, wmask_c;
  logic [WORDSIZE-1:0] bitmask_c, wshift_c, rshift_c, keep_c, ext_c;
  logic [BIT_W-1:0]    msb_c;

  assign bus.req_ready  = ready_q;
  assign bus.init_done  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.resp_rdata = resp_rdata_q;

  // Address decode and error classification
  assign accept_c  = bus.req_valid && ready_q;
  assign row_c     = bus.req_addr[ADDR_WIDTH-1:LANE_W];
  assign lane_c    = bus.req_addr[LANE_W-1:0];
  assign row_idx_c = CNT_W'(row_c);
  assign err_c     = (|(bus.req_addr & ADDR_WIDTH'((32'd1 << bus.req_size) - 32'd1)))
                   || (32'(row_c) >= SIZE)
                   || ((WORDSIZE == 32) && (bus.req_size == 2'd3));

  always_comb begin
    byte_en_c = '1;
    keep_c    = '1;
    msb_c     = BIT_W'(WORDSIZE - 1);
    case (bus.req_size)
      2'd0: begin byte_en_c = BYTES'(8'h01); keep_c = WORDSIZE'(8'hFF);         msb_c = BIT_W'(7);  end
      2'd1: begin byte_en_c = BYTES'(8'h03); keep_c = WORDSIZE'(16'hFFFF);      msb_c = BIT_W'(15); end
      2'd2: begin byte_en_c = BYTES'(8'h0F); keep_c = WORDSIZE'(32'hFFFF_FFFF); msb_c = BIT_W'(31); end
      default: ;
    endcase
  end

  assign wmask_c  = byte_en_c << lane_c;
  assign wshift_c = bus.req_wdata << {lane_c, 3'b000};
  assign rshift_c = mem_q[row_idx_c] >> {lane_c, 3'b000};
  assign sign_c   = !bus.req_unsigned && (bus.req_size != 2'd3) && rshift_c[msb_c];
  assign ext_c    = (rshift_c & keep_c) | (sign_c ? ~keep_c : '0);

  for (genvar b = 0; b < BYTES; b++) begin : g_bitmask
    assign bitmask_c[8*b +: 8] = {8{wmask_c[b]}};
  end

`ifdef DATA_MEMORY_STATS_EN
  logic resp_write_q, resp_write_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef DATA_MEMORY_STATS_EN
      resp_write_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef DATA_MEMORY_STATS_EN
      resp_write_q <= resp_write_d;
`endif
    end
  end

  // Sweep rows while in INIT, then serve one request per cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    init_we_c    = 1'b0;
    store_we_c   = 1'b0;
`ifdef DATA_MEMORY_STATS_EN
    resp_write_d = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        init_we_c = 1'b1;
        if (cnt_q == CNT_W'(SIZE - 1)) state_d = ST_READY;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_READY: begin
        if (accept_c) begin
          resp_valid_d = 1'b1;
`ifdef DATA_MEMORY_STATS_EN
          resp_write_d = bus.req_write;
`endif
          if (err_c)              resp_error_d = 1'b1;
          else if (bus.req_write) store_we_c   = 1'b1;
          else                    resp_rdata_d = ext_c;
        end
      end
      default: state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_READY);
  end

  // Array has no reset; only the sweep clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_we_c)
        mem_q[cnt_q] <= '0;
      else if (store_we_c)
        mem_q[row_idx_c] <= (mem_q[row_idx_c] & ~bitmask_c) | (wshift_c & bitmask_c);
    end
  end

`ifdef DATA_MEMORY_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (resp_valid_q) begin
      if (resp_error_q) begin
        if (stat_errors != '1) stat_errors <= stat_errors + 32'd1;
      end else if (resp_write_q) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (SIZE 32 and 16) share stimulus;
// a byte-level model predicts every cycle, directed literals pin the model.
module tb_data_memory_ctrl;
  localparam int unsigned WS = 64;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic [WS-1:0] req_wdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_memory_if #(.WORDSIZE(WS), .ADDR_WIDTH(AW)) bus0 ();
  data_memory_if #(.WORDSIZE(WS), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.req_valid = req_valid;    assign bus1.req_valid = req_valid;
  assign bus0.req_write = req_write;    assign bus1.req_write = req_write;
  assign bus0.req_addr  = req_addr;     assign bus1.req_addr  = req_addr;
  assign bus0.req_size  = req_size;     assign bus1.req_size  = req_size;
  assign bus0.req_unsigned = req_unsigned; assign bus1.req_unsigned = req_unsigned;
  assign bus0.req_wdata = req_wdata;    assign bus1.req_wdata = req_wdata;

`ifdef DATA_MEMORY_STATS_EN
  logic [31:0] sl0, ss0, se0, sl1, ss1, se1;
`endif

  data_memory_ctrl #(.WORDSIZE(WS), .SIZE(32), .ADDR_WIDTH(AW)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
`ifdef DATA_MEMORY_STATS_EN
    , .stat_loads(sl0), .stat_stores(ss0), .stat_errors(se0)
`endif
  );

  data_memory_ctrl #(.WORDSIZE(WS), .SIZE(16), .ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef DATA_MEMORY_STATS_EN
    , .stat_loads(sl1), .stat_stores(ss1), .stat_errors(se1)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Model state, one slot per instance
  int          msize [2] = '{32, 16};
  logic [7:0]  mm [2][256];
  int          since [2];
  bit          e_ready [2], e_valid [2], e_err [2], e_wr [2];
  logic [63:0] e_rd [2];
  int          s_ld [2], s_st [2], s_er [2];
  bit          armed = 1'b0;

  task automatic model_edge(input int d);
    int n;
    int a;
    logic [63:0] v;
    if (reset) begin
      since[d] = 0; e_ready[d] = 0; e_valid[d] = 0; e_err[d] = 0; e_wr[d] = 0; e_rd[d] = '0;
      s_ld[d] = 0; s_st[d] = 0; s_er[d] = 0;
      for (int i = 0; i < 256; i++) mm[d][i] = 8'h00;
    end else begin
      if (e_valid[d]) begin
        if (e_err[d]) s_er[d]++;
        else if (e_wr[d]) s_st[d]++;
        else s_ld[d]++;
      end
      e_valid[d] = 0; e_err[d] = 0; e_rd[d] = '0;
      if (req_valid && e_ready[d]) begin
        n = 1 << req_size;
        a = int'(req_addr);
        e_valid[d] = 1;
        e_wr[d] = req_write;
        if ((a % n) != 0 || (a / 8) >= msize[d]) begin
          e_err[d] = 1;
        end else if (req_write) begin
          for (int i = 0; i < n; i++) mm[d][a + i] = req_wdata[8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < n; i++) v = v | (64'(mm[d][a + i]) << (8 * i));
          if (!req_unsigned && n < 8 && v[8*n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
          e_rd[d] = v;
        end
      end
      since[d]++;
      e_ready[d] = (since[d] >= msize[d]);
    end
  endtask

  // Per-cycle comparison against the model, just after each rising edge
  always begin
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    if (reset) armed = 1'b1;
    #1;
    if (armed) begin
      check("ready0", 64'(bus0.req_ready), 64'(e_ready[0]));
      check("done0",  64'(bus0.init_done), 64'(e_ready[0]));
      check("valid0", 64'(bus0.resp_valid), 64'(e_valid[0]));
      check("ready1", 64'(bus1.req_ready), 64'(e_ready[1]));
      check("done1",  64'(bus1.init_done), 64'(e_ready[1]));
      check("valid1", 64'(bus1.resp_valid), 64'(e_valid[1]));
      if (e_valid[0]) begin
        check("rdata0", bus0.resp_rdata, e_rd[0]);
        check("err0", 64'(bus0.resp_error), 64'(e_err[0]));
      end
      if (e_valid[1]) begin
        check("rdata1", bus1.resp_rdata, e_rd[1]);
        check("err1", 64'(bus1.resp_error), 64'(e_err[1]));
      end
`ifdef DATA_MEMORY_STATS_EN
      check("sl0", 64'(sl0), 64'(s_ld[0])); check("ss0", 64'(ss0), 64'(s_st[0]));
      check("se0", 64'(se0), 64'(s_er[0])); check("sl1", 64'(sl1), 64'(s_ld[1]));
      check("ss1", 64'(ss1), 64'(s_st[1])); check("se1", 64'(se1), 64'(s_er[1]));
`endif
    end
  end

  task automatic drive(input bit w, input logic [7:0] a, input logic [1:0] sz,
                       input bit u, input logic [63:0] wd);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
  endtask

  // One isolated request with literal expectations for both instances
  task automatic req(input string name, input bit w, input logic [7:0] a, input logic [1:0] sz,
                     input bit u, input logic [63:0] wd, input logic [63:0] exp,
                     input bit err0, input bit err1);
    @(negedge clk);
    drive(w, a, sz, u, wd);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, "_v0"}, 64'(bus0.resp_valid), 64'd1);
    check({name, "_d0"}, bus0.resp_rdata, err0 ? 64'd0 : exp);
    check({name, "_e0"}, 64'(bus0.resp_error), 64'(err0));
    check({name, "_v1"}, 64'(bus1.resp_valid), 64'd1);
    check({name, "_d1"}, bus1.resp_rdata, err1 ? 64'd0 : exp);
    check({name, "_e1"}, 64'(bus1.resp_error), 64'(err1));
  endtask

  // Counts falling edges from reset release until each instance is ready
  task automatic measure_init(input string name);
    int n, r0, r1;
    n = 0; r0 = -1; r1 = -1;
    while ((r0 < 0 || r1 < 0) && n < 100) begin
      @(negedge clk);
      n++;
      if (r0 < 0 && bus0.req_ready === 1'b1) r0 = n;
      if (r1 < 0 && bus1.req_ready === 1'b1) r1 = n;
    end
    check({name, "_lat0"}, 64'(r0), 64'd32);
    check({name, "_lat1"}, 64'(r1), 64'd16);
  endtask

  bit          bw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [63:0] bd [4] = '{64'd1, 64'd0, 64'd2, 64'd0};
  logic [63:0] bx [4] = '{64'd0, 64'd1, 64'd0, 64'd2};

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    measure_init("init");

    req("ld_zero0", 0, 8'h00, 2'd3, 0, '0, 64'd0, 0, 0);
    req("ld_zeroF8", 0, 8'hF8, 2'd3, 0, '0, 64'd0, 0, 1);

    req("st_dbl", 1, 8'h10, 2'd3, 0, 64'h8877665544332211, 64'd0, 0, 0);
    req("ld_b13", 0, 8'h13, 2'd0, 0, '0, 64'h44, 0, 0);
    req("ld_h16", 0, 8'h16, 2'd1, 0, '0, 64'hFFFF_FFFF_FFFF_8877, 0, 0);
    req("ld_h14u", 0, 8'h14, 2'd1, 1, '0, 64'h6655, 0, 0);
    req("ld_w14", 0, 8'h14, 2'd2, 0, '0, 64'hFFFF_FFFF_8877_6655, 0, 0);

    req("st_b20", 1, 8'h20, 2'd0, 0, 64'hAAAA_AAAA_AAAA_AAF0, 64'd0, 0, 0);
    req("ld_b20s", 0, 8'h20, 2'd0, 0, '0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
    req("ld_b20u", 0, 8'h20, 2'd0, 1, '0, 64'hF0, 0, 0);
    req("ld_d20", 0, 8'h20, 2'd3, 0, '0, 64'hF0, 0, 0);

    req("mis_h11", 0, 8'h11, 2'd1, 0, '0, 64'd0, 1, 1);
    req("mis_d14", 0, 8'h14, 2'd3, 0, '0, 64'd0, 1, 1);
    req("st_wFC", 1, 8'hFC, 2'd2, 0, 64'h1111_1111_DEAD_BEEF, 64'd0, 0, 1);
    req("ld_wFCu", 0, 8'hFC, 2'd2, 1, '0, 64'hDEAD_BEEF, 0, 1);
    req("ld_wFCs", 0, 8'hFC, 2'd2, 0, '0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 1);
    req("ld_d78", 0, 8'h78, 2'd3, 0, '0, 64'd0, 0, 0);

    // Four requests back to back, each response checked the following cycle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_v", 64'(bus0.resp_valid), 64'd1);
        check("b2b_d", bus0.resp_rdata, bx[i-1]);
      end
      if (i < 4) drive(bw[i], 8'h08, 2'd3, 0, bd[i]);
      else req_valid = 1'b0;
    end

    // Store on the same edge as reset is dropped
    @(negedge clk);
    drive(1, 8'h30, 2'd3, 0, 64'h55);
    reset = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    check("rst_drop_v", 64'(bus0.resp_valid), 64'd0);
    check("rst_ready", 64'(bus0.req_ready), 64'd0);

    // Reset again part-way through the sweep
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure_init("resweep");
`ifdef DATA_MEMORY_STATS_EN
    check("stat_ld_clr", 64'(sl0), 64'd0);
    check("stat_st_clr", 64'(ss0), 64'd0);
    check("stat_er_clr", 64'(se0), 64'd0);
`endif
    req("ld_d30", 0, 8'h30, 2'd3, 0, '0, 64'd0, 0, 0);
    req("ld_d10", 0, 8'h10, 2'd3, 0, '0, 64'd0, 0, 0);
    req("ld_d08", 0, 8'h08, 2'd3, 0, '0, 64'd0, 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
